// File: rtl/scan_select.sv
// Registered N-channel, W-bit selector with manual select and round-robin auto-scan.
// Optional mask-driven channel skipping in scan mode: define SCAN_SELECT_MASK_SKIP_EN.
module scan_select #(
   parameter  int N     = 4,
   parameter  int W     = 1,
   parameter  int DWELL = 4,
   localparam int SELW  = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N*W-1:0]    in,
   input  logic [SELW-1:0]   sel,
   input  logic              mode,
   input  logic [N-1:0]      mask,
   output logic [W-1:0]      out,
   output logic [SELW-1:0]   cur_sel,
   output logic              valid,
   output logic              wrap
);

   localparam int              CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int              NSLOT    = 2 ** SELW;
   localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
   localparam logic [SELW-1:0] SEL_LAST = SELW'(N - 1);

   typedef enum logic {MANUAL, SCAN} state_t;

   state_t          state_reg;
   logic [CW-1:0]   cnt_reg;
   logic [W-1:0]    ch [NSLOT];
   logic [SELW-1:0] adv_sel;
   logic            adv_wrap;
   logic [SELW-1:0] first_sel;
   logic            any_en;

   // Slots beyond N read as zero so an out-of-range select yields out = 0.
   generate
      for (genvar gi = 0; gi < NSLOT; gi++) begin : g_ch
         if (gi < N) begin : g_live
            assign ch[gi] = in[gi*W +: W];
         end else begin : g_pad
            assign ch[gi] = '0;
         end
      end
   endgenerate

`ifdef SCAN_SELECT_MASK_SKIP_EN
   logic [SELW-1:0] hi_sel;
   logic            found_hi;

   // Descending scan: the last hit is the lowest enabled index overall and above cur_sel.
   always_comb begin
      first_sel = '0;
      any_en    = 1'b0;
      hi_sel    = '0;
      found_hi  = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (mask[i]) begin
            first_sel = SELW'(i);
            any_en    = 1'b1;
            if (i > int'(cur_sel)) begin
               hi_sel   = SELW'(i);
               found_hi = 1'b1;
            end
         end
      end
      adv_sel  = found_hi ? hi_sel : first_sel;
      adv_wrap = !found_hi;
   end
`else
   logic unused_mask;
   assign unused_mask = ^mask;

   // Explicit wrap at N-1: N need not be a power of two.
   always_comb begin
      first_sel = '0;
      any_en    = 1'b1;
      adv_wrap  = (cur_sel == SEL_LAST);
      adv_sel   = adv_wrap ? '0 : cur_sel + SELW'(1);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= MANUAL;
         cnt_reg   <= '0;
         out       <= '0;
         cur_sel   <= '0;
         valid     <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         state_reg <= mode ? SCAN : MANUAL;
         if (!mode) begin
            cur_sel <= sel;
            out     <= ch[sel];
            valid   <= (int'(sel) < N);
            cnt_reg <= '0;
            wrap    <= 1'b0;
         end else if (!any_en) begin
            // Nothing enabled: park position and dwell count, blank the output.
            out   <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
         end else if (state_reg == MANUAL) begin
            cur_sel <= first_sel;
            out     <= ch[first_sel];
            valid   <= 1'b1;
            cnt_reg <= '0;
            wrap    <= 1'b0;
         end else if (cnt_reg != CNT_LAST) begin
            out     <= ch[cur_sel];
            valid   <= (int'(cur_sel) < N);
            cnt_reg <= cnt_reg + CW'(1);
            wrap    <= 1'b0;
         end else begin
            cur_sel <= adv_sel;
            out     <= ch[adv_sel];
            valid   <= 1'b1;
            cnt_reg <= '0;
            wrap    <= adv_wrap;
         end
      end
   end

endmodule

// File: tb/tb_scan_select.sv
// Self-checking bench for scan_select (N=4, W=8, DWELL=2) plus an N=3 instance.
// Mask tests run only when SCAN_SELECT_MASK_SKIP_EN is defined.
module tb_scan_select;

   localparam int N     = 4;
   localparam int W     = 8;
   localparam int DWELL = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [N*W-1:0] in_bus;
   logic [1:0]    sel;
   logic          mode;
   logic [N-1:0]  mask;
   logic [W-1:0]  out;
   logic [1:0]    cur_sel;
   logic          valid;
   logic          wrap;

   logic [3*W-1:0] in3;
   logic [1:0]    sel3;
   logic          mode3;
   logic [W-1:0]  out3;
   logic [1:0]    cur3;
   logic          valid3;
   logic          wrap3;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   scan_select #(.N(N), .W(W), .DWELL(DWELL)) dut (
      .clk(clk), .rst(rst), .in(in_bus), .sel(sel), .mode(mode), .mask(mask),
      .out(out), .cur_sel(cur_sel), .valid(valid), .wrap(wrap)
   );

   scan_select #(.N(3), .W(W), .DWELL(DWELL)) dut3 (
      .clk(clk), .rst(rst), .in(in3), .sel(sel3), .mode(mode3), .mask(3'b111),
      .out(out3), .cur_sel(cur3), .valid(valid3), .wrap(wrap3)
   );

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endfunction

   // Behavioural model: scan position derived from cycles elapsed since scan entry.
   logic [W-1:0] e_out;
   int           e_sel;
   logic         e_valid, e_wrap;
   bit           model_live = 0;
   bit           in_scan = 0;
   int           k = 0;

   always @(posedge clk) begin
      int lst[$];
      int idx;
      if (rst) begin
         e_out = '0; e_sel = 0; e_valid = 0; e_wrap = 0; in_scan = 0; k = 0;
      end else if (!mode) begin
         in_scan = 0;
         e_wrap  = 0;
         e_sel   = int'(sel);
         e_valid = (e_sel < N);
         e_out   = e_valid ? in_bus[e_sel*W +: W] : '0;
      end else begin
         if (!in_scan) begin k = 0; in_scan = 1; end
         else k++;
         lst = {};
         for (int i = 0; i < N; i++) begin
`ifdef SCAN_SELECT_MASK_SKIP_EN
            if (mask[i]) lst.push_back(i);
`else
            lst.push_back(i);
`endif
         end
         if (lst.size() == 0) begin
            e_out = '0; e_valid = 0; e_wrap = 0;
         end else begin
            idx     = (k / DWELL) % lst.size();
            e_sel   = lst[idx];
            e_out   = in_bus[e_sel*W +: W];
            e_valid = 1;
            e_wrap  = (k > 0) && (k % DWELL == 0) && (idx == 0);
         end
      end
      model_live = 1;
   end

   always @(negedge clk) begin
      if (model_live) begin
         chk("model.out",     32'(out),     32'(e_out));
         chk("model.cur_sel", 32'(cur_sel), 32'(e_sel));
         chk("model.valid",   32'(valid),   32'(e_valid));
         chk("model.wrap",    32'(wrap),    32'(e_wrap));
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic lit(input string nm, input int c, input logic [7:0] o, input bit v, input bit w);
      chk({nm, ".cur_sel"}, 32'(cur_sel), 32'(c));
      chk({nm, ".out"},     32'(out),     32'(o));
      chk({nm, ".valid"},   32'(valid),   32'(v));
      chk({nm, ".wrap"},    32'(wrap),    32'(w));
      $display("step %s: cur_sel=%0d out=%h valid=%0b wrap=%0b", nm, cur_sel, out, valid, wrap);
   endtask

   task automatic lit3(input string nm, input int c, input logic [7:0] o, input bit v, input bit w);
      chk({nm, ".cur_sel"}, 32'(cur3),   32'(c));
      chk({nm, ".out"},     32'(out3),   32'(o));
      chk({nm, ".valid"},   32'(valid3), 32'(v));
      chk({nm, ".wrap"},    32'(wrap3),  32'(w));
      $display("step %s: cur_sel=%0d out=%h valid=%0b wrap=%0b", nm, cur3, out3, valid3, wrap3);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      int scan_sel[10];
      logic [7:0] scan_out[10];
      scan_sel = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
      scan_out = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44, 8'h11, 8'h11};

      rst = 1; mode = 0; sel = 2;
      in_bus = {8'h44, 8'h33, 8'h22, 8'h11};
      in3 = {8'h77, 8'h66, 8'h55}; sel3 = 0; mode3 = 0;
`ifdef SCAN_SELECT_MASK_SKIP_EN
      mask = 4'hF;
`else
      mask = 4'h0;
`endif
      tick(); tick();
      lit("reset", 0, 8'h00, 0, 0);

      rst = 0;
      tick(); lit("manual.sel2", 2, 8'h33, 1, 0);
      sel = 0; tick(); lit("manual.sel0", 0, 8'h11, 1, 0);
      sel = 3; tick(); lit("manual.sel3", 3, 8'h44, 1, 0);
      sel = 1; tick(); lit("manual.sel1", 1, 8'h22, 1, 0);
      in_bus[15:8] = 8'hA5; tick(); lit("manual.live", 1, 8'hA5, 1, 0);
      in_bus[15:8] = 8'h22;

      mode = 1; sel = 3;
      for (int i = 0; i < 10; i++) begin
         tick();
         lit($sformatf("scan.k%0d", i), scan_sel[i], scan_out[i], 1, (i == 8));
      end
      tick(); tick(); tick();
      lit("scan.at2", 2, 8'h33, 1, 0);

      mode = 0; sel = 1; tick(); lit("leave", 1, 8'h22, 1, 0);
      mode = 1; tick(); lit("reenter.k0", 0, 8'h11, 1, 0);
      tick(); lit("reenter.k1", 0, 8'h11, 1, 0);
      for (int i = 0; i < 5; i++) tick();
      lit("reenter.k6", 3, 8'h44, 1, 0);
      rst = 1; tick(); lit("rst.midscan", 0, 8'h00, 0, 0);
      rst = 0; mode = 0; sel = 0; tick();

`ifdef SCAN_SELECT_MASK_SKIP_EN
      begin
         int ms[6];
         ms = '{1, 1, 3, 3, 1, 1};
         mask = 4'b1010; mode = 1;
         for (int i = 0; i < 6; i++) begin
            tick();
            lit($sformatf("mask1010.k%0d", i), ms[i], (ms[i] == 1) ? 8'h22 : 8'h44, 1, (i == 4));
         end
         mode = 0; tick();
         mask = 4'b0000; mode = 1; tick();
         chk("mask0.out", 32'(out), 32'h0);
         chk("mask0.valid", 32'(valid), 32'h0);
         mode = 0; tick();
         mask = 4'b0100; mode = 1;
         for (int i = 0; i < 6; i++) begin
            tick();
            lit($sformatf("mask0100.k%0d", i), 2, 8'h33, 1, (i > 0) && (i % 2 == 0));
         end
         mode = 0; mask = 4'hF; tick();
      end
`endif

      sel3 = 3; tick(); lit3("n3.oor", 3, 8'h00, 0, 0);
      sel3 = 2; tick(); lit3("n3.sel2", 2, 8'h77, 1, 0);
      mode3 = 1;
      begin
         int s3[7];
         s3 = '{0, 0, 1, 1, 2, 2, 0};
         for (int i = 0; i < 7; i++) begin
            tick();
            lit3($sformatf("n3.scan.k%0d", i), s3[i],
                 (s3[i] == 0) ? 8'h55 : ((s3[i] == 1) ? 8'h66 : 8'h77), 1, (i == 6));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
